// File: rtl/matrix_op_sequencer.sv
// Sequencer for the N x N signed matrix datapath: walks element indices,
// reads banks A/B, computes each result element and writes bank C.
module matrix_op_sequencer #(
    parameter int unsigned N    = 5,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 5,
    parameter int unsigned ACCW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    opcode,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] rd_data_a,
    input  logic [DW-1:0] rd_data_b,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ovf
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SCL = 3'b011;
    localparam logic [2:0] OP_TRN = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b101;

    localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          row, col, k;
    logic [CW-1:0]          row_d, col_d, k_d;
    logic [2:0]             op, op_d;
    logic                   err_d, ovf_d;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] a_ext, b_ext, prod, result;
    logic [DW-1:0]          sat_val;
    logic                   clamp;

    // Row-major linear address of element (r, c)
    function automatic logic [AW-1:0] lin(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return AW'(32'(r) * N + 32'(c));
    endfunction

    // Sign-extended operands and their full-width product
    always_comb begin
        a_ext = {{(ACCW-DW){rd_data_a[DW-1]}}, rd_data_a};
        b_ext = {{(ACCW-DW){rd_data_b[DW-1]}}, rd_data_b};
        prod  = a_ext * b_ext;
    end

    // Per-element result and saturation to the element range
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = acc + prod;
            OP_SCL:  result = prod;
            OP_TRN:  result = a_ext;
            OP_NEG:  result = -a_ext;
            default: result = '0;
        endcase
        clamp   = 1'b0;
        sat_val = result[DW-1:0];
        if (result > SMAX) begin
            clamp   = 1'b1;
            sat_val = SMAX[DW-1:0];
        end else if (result < SMIN) begin
            clamp   = 1'b1;
            sat_val = SMIN[DW-1:0];
        end
    end

    // Write data follows the bank read data, so it is only driven in WRITE
    always_comb begin
        wr_data = '0;
        if (state == WRITE) wr_data = sat_val;
    end

    // Next-state, counter and status-flag logic
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        k_d     = k;
        op_d    = op;
        err_d   = err;
        ovf_d   = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    op_d  = opcode;
                    row_d = '0;
                    col_d = '0;
                    k_d   = '0;
                    ovf_d = 1'b0;
                    if (opcode > OP_NEG) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (op == OP_MUL && k != LAST) k_d = k + CW'(1);
                else                           state_d = WRITE;
            end
            WRITE: begin
                if (clamp) ovf_d = 1'b1;
                k_d     = '0;
                state_d = FETCH;
                if (col == LAST) begin
                    col_d = '0;
                    if (row == LAST) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row + CW'(1);
                    end
                end else begin
                    col_d = col + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            op        <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            k         <= k_d;
            op        <= op_d;
            err       <= err_d;
            ovf       <= ovf_d;
            wr_en     <= (state_d == WRITE);
            wr_addr   <= lin(row_d, col_d);
            busy      <= (state_d == FETCH) || (state_d == WRITE);
            done      <= (state_d == DONE);
            if (op_d == OP_TRN)      rd_addr_a <= lin(col_d, row_d);
            else if (op_d == OP_MUL) rd_addr_a <= lin(row_d, k_d);
            else                     rd_addr_a <= lin(row_d, col_d);
            if (op_d == OP_MUL)      rd_addr_b <= lin(k_d, col_d);
            else if (op_d == OP_SCL) rd_addr_b <= '0;
            else                     rd_addr_b <= lin(row_d, col_d);
        end
    end

    // Dot-product accumulator: cleared on k=0, adds the previous fetch after that
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (state == FETCH) begin
            if (k == '0) acc <= '0;
            else         acc <= acc + prod;
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a 1-cycle-latency bank model.
module tb_matrix_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [7:0] rd_data_a, rd_data_b, wr_data;
    logic       wr_en, busy, done, err, ovf;

    logic signed [7:0] mem_a [25];
    logic signed [7:0] mem_b [25];
    logic [7:0]        cap_c [25];
    int                exp_c [25];

    int n_checks = 0;
    int n_fail   = 0;

    matrix_op_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Bank model: read data valid one cycle after the address
    always @(posedge clk) begin
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one start pulse, then track the run until done (bounded)
    task automatic run_op(input logic [2:0] op, input int poke,
                          output int done_cyc, output int nwr,
                          output int nbusy, output bit order_ok);
        int cyc;
        for (int i = 0; i < 25; i++) cap_c[i] = 8'h5A;
        nwr = 0; nbusy = 0; order_ok = 1'b1; done_cyc = -1;
        @(negedge clk);
        start = 1'b1; opcode = op;
        @(negedge clk);
        start = 1'b0; opcode = 3'b111;
        cyc = 1;
        while (cyc < 400) begin
            if (wr_en) begin
                if (int'(wr_addr) != nwr) order_ok = 1'b0;
                if (wr_addr < 5'd25) cap_c[wr_addr] = wr_data;
                nwr++;
            end
            if (busy) nbusy++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == poke);
            if (cyc == poke) opcode = 3'b010;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input int poke, input int exp_done,
                                 input int exp_ovf, input int exp_err);
        int dc, nw, nb;
        bit ord;
        run_op(op, poke, dc, nw, nb, ord);
        check({name, " done cycle"}, dc, exp_done);
        check({name, " write count"}, nw, exp_err ? 0 : 25);
        check({name, " busy cycles"}, nb, exp_err ? 0 : exp_done - 1);
        check({name, " write order"}, int'(ord), 1);
        check({name, " ovf"}, int'(ovf), exp_ovf);
        check({name, " err"}, int'(err), exp_err);
        if (exp_err == 0)
            for (int i = 0; i < 25; i++)
                check($sformatf("%s C[%0d]", name, i), int'($signed(cap_c[i])), exp_c[i]);
    endtask

    task automatic load_mul_identity();
        for (int i = 0; i < 25; i++) begin
            mem_a[i] = (i / 5 == i % 5) ? 8'sd1 : 8'sd0;
            mem_b[i] = 8'(i);
            exp_c[i] = i;
        end
    endtask

    initial begin
        int cyc, stray;
        reset = 1'b1; start = 1'b0; opcode = 3'b000;
        for (int i = 0; i < 25; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        check("reset ovf", int'(ovf), 0);
        check("reset wr_en", int'(wr_en), 0);
        check("reset wr_addr", int'(wr_addr), 0);
        check("reset wr_data", int'(wr_data), 0);
        check("reset rd_addr_a", int'(rd_addr_a), 0);
        check("reset rd_addr_b", int'(rd_addr_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // ADD with a stray start at cycle 10
        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'sd1; mem_b[i] = 8'sd2; exp_c[i] = 3; end
        run_and_check("add", 3'b000, 10, 51, 0, 0);

        for (int i = 0; i < 25; i++) begin mem_a[i] = -8'sd100; mem_b[i] = 8'sd100; exp_c[i] = -128; end
        run_and_check("sub_sat", 3'b001, 0, 51, 1, 0);

        for (int i = 0; i < 25; i++) exp_c[i] = 0;
        run_and_check("add_nosat", 3'b000, 0, 51, 0, 0);

        load_mul_identity();
        run_and_check("mul_id", 3'b010, 0, 151, 0, 0);

        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'sd10; mem_b[i] = 8'sd10; exp_c[i] = 127; end
        run_and_check("mul_sat", 3'b010, 0, 151, 1, 0);

        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'(i); exp_c[i] = (i % 5) * 5 + i / 5; end
        run_and_check("trans", 3'b100, 0, 51, 0, 0);

        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'(i * 3 - 40); exp_c[i] = 40 - i * 3; end
        mem_a[0] = -8'sd128; exp_c[0] = 127;
        run_and_check("neg", 3'b101, 0, 51, 1, 0);

        for (int i = 0; i < 25; i++) begin
            mem_a[i] = 8'(i - 12); mem_b[i] = 8'sd50; exp_c[i] = 3 * (i - 12);
        end
        mem_b[0] = 8'sd3;
        run_and_check("scale", 3'b011, 0, 51, 0, 0);

        run_and_check("bad_op", 3'b111, 0, 1, 0, 1);

        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'sd1; mem_b[i] = 8'sd2; exp_c[i] = 3; end
        run_and_check("add_after_err", 3'b000, 0, 51, 0, 0);

        // Reset in the middle of a MUL run
        load_mul_identity();
        @(negedge clk);
        start = 1'b1; opcode = 3'b010;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin @(negedge clk); cyc++; end
        check("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid-reset wr_en", int'(wr_en), 0);
        check("mid-reset busy", int'(busy), 0);
        stray = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en || busy) stray++;
        end
        check("post-reset activity", stray, 0);
        run_and_check("mul_after_reset", 3'b010, 0, 151, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
